// File: rtl/sr_drive_pkg.sv
// Shared types and constants for the SR latch drive controller.
// FSM state encoding and the error codes reported on err_code.
package sr_drive_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_CONFLICT = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

endpackage

// File: rtl/sr_req_filter.sv
// Request conditioner: 2-FF synchronizer, debounce, rising-edge event.
// evt is a registered one-cycle pulse on each debounced rising edge.
module sr_req_filter #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic evt
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    // The level flips on the count that would take cnt to DEB_CYCLES.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // Two-stage synchronizer for the raw asynchronous request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= req;
            sync2 <= sync1;
        end
    end

    // Count consecutive samples disagreeing with the level; flip when stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            level <= 1'b0;
            evt   <= 1'b0;
        end else begin
            evt <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
                evt   <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_drive_ctrl.sv
// Command front-end for a dataflow SR latch: filtered requests become
// exclusive registered set/rst pulses, followed by a Q readback check.
module sr_drive_ctrl
    import sr_drive_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned PULSE_W    = 2,
    parameter int unsigned CHK_DLY    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_req,
    input  logic       clr_req,
    input  logic       err_clr,
    input  logic       q_fb,
    output logic       s_out,
    output logic       r_out,
    output logic       q_exp,
    output logic       busy,
    output logic       err,
    output logic [1:0] err_code
);

    localparam logic [3:0] PW_LAST = 4'(PULSE_W - 1);
    localparam logic [3:0] CD_LAST = 4'(CHK_DLY - 1);

    logic       set_evt;
    logic       clr_evt;
    logic       set_pend;
    logic       clr_pend;
    state_t     state;
    logic [3:0] cnt;
    logic       idle;
    logic       set_take;
    logic       clr_take;
    logic       conflict;
    logic       overflow;
    logic       mismatch;
    logic       new_err;
    logic [1:0] new_code;

    sr_req_filter #(.DEB_CYCLES(DEB_CYCLES)) u_set_filter (
        .clk (clk),
        .rst (rst),
        .req (set_req),
        .evt (set_evt)
    );

    sr_req_filter #(.DEB_CYCLES(DEB_CYCLES)) u_clr_filter (
        .clk (clk),
        .rst (rst),
        .req (clr_req),
        .evt (clr_evt)
    );

    // A set pend seen in IDLE is always taken: executed, or discarded
    // when a clear wins the same cycle.
    assign idle     = (state == IDLE);
    assign clr_take = idle && clr_pend;
    assign set_take = idle && set_pend;
    assign conflict = idle && clr_pend && set_pend;
    assign overflow = (set_evt && set_pend && !set_take)
                   || (clr_evt && clr_pend && !clr_take);
    assign mismatch = (state == SETTLE) && (cnt == CD_LAST)
                   && (q_fb != q_exp);
    assign new_err  = mismatch || conflict || overflow;

    // Fixed priority when several errors coincide.
    always_comb begin
        new_code = ERR_NONE;
        if (mismatch)      new_code = ERR_MISMATCH;
        else if (conflict) new_code = ERR_CONFLICT;
        else if (overflow) new_code = ERR_OVERFLOW;
    end

    // One-deep pending flags; a same-cycle take and event keeps the new one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_pend <= 1'b0;
            clr_pend <= 1'b0;
        end else begin
            set_pend <= set_evt || (set_pend && !set_take);
            clr_pend <= clr_evt || (clr_pend && !clr_take);
        end
    end

    // Command FSM with registered drive, busy and expected-state outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            s_out <= 1'b0;
            r_out <= 1'b0;
            q_exp <= 1'b0;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (clr_pend) begin
                        state <= DRIVE;
                        r_out <= 1'b1;
                        q_exp <= 1'b0;
                        busy  <= 1'b1;
                    end else if (set_pend) begin
                        state <= DRIVE;
                        s_out <= 1'b1;
                        q_exp <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt == PW_LAST) begin
                        state <= SETTLE;
                        cnt   <= '0;
                        s_out <= 1'b0;
                        r_out <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == CD_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    s_out <= 1'b0;
                    r_out <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky first-error capture; a new error beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else if (new_err && (!err || err_clr)) begin
            err      <= 1'b1;
            err_code <= new_code;
        end else if (err_clr) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end
    end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Self-checking bench for sr_drive_ctrl: directed scenarios plus
// randomized commands checked against latency arithmetic.
module tb_sr_drive_ctrl;

    localparam int DEB = 4;
    localparam int PW  = 2;
    localparam int CD  = 2;
    localparam int LAT = 2 + DEB + 2;
    localparam int PW2 = 15;
    localparam int CD2 = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       set_req = 1'b0;
    logic       clr_req = 1'b0;
    logic       err_clr = 1'b0;
    logic       q_fb;
    logic       s_out, r_out, q_exp, busy, err;
    logic [1:0] err_code;

    logic       set2 = 1'b0;
    logic       clr2 = 1'b0;
    logic       err_clr2 = 1'b0;
    logic       q_fb2;
    logic       s_out2, r_out2, q_exp2, busy2, err2;
    logic [1:0] err_code2;

    logic       lq = 1'b0;
    logic       lq2 = 1'b0;
    logic       force_en = 1'b0;
    logic       force_val = 1'b0;
    logic       prev_q = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int s2_pulses = 0;

    always #5 clk = ~clk;

    // Latch models: set/rst gated by clk high.
    always @(clk or s_out or r_out)
        if (clk) begin
            if (s_out) lq = 1'b1;
            else if (r_out) lq = 1'b0;
        end

    always @(clk or s_out2 or r_out2)
        if (clk) begin
            if (s_out2) lq2 = 1'b1;
            else if (r_out2) lq2 = 1'b0;
        end

    always @(posedge s_out2) s2_pulses = s2_pulses + 1;

    assign q_fb  = force_en ? force_val : lq;
    assign q_fb2 = lq2;

    sr_drive_ctrl #(.DEB_CYCLES(DEB), .PULSE_W(PW), .CHK_DLY(CD)) dut (
        .clk      (clk),
        .rst      (rst),
        .set_req  (set_req),
        .clr_req  (clr_req),
        .err_clr  (err_clr),
        .q_fb     (q_fb),
        .s_out    (s_out),
        .r_out    (r_out),
        .q_exp    (q_exp),
        .busy     (busy),
        .err      (err),
        .err_code (err_code)
    );

    sr_drive_ctrl #(.DEB_CYCLES(DEB), .PULSE_W(PW2), .CHK_DLY(CD2)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .set_req  (set2),
        .clr_req  (clr2),
        .err_clr  (err_clr2),
        .q_fb     (q_fb2),
        .s_out    (s_out2),
        .r_out    (r_out2),
        .q_exp    (q_exp2),
        .busy     (busy2),
        .err      (err2),
        .err_code (err_code2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        rst = 1'b0;
        cyc();
        cyc();
        got = {s_out, r_out, q_exp, busy, err, err_code};
        n_checks++;
        if (got !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_dut outputs got %b want 0000000", got);
        end
        got = {s_out2, r_out2, q_exp2, busy2, err2, err_code2};
        n_checks++;
        if (got !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_dut2 outputs got %b want 0000000", got);
        end
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        got = {s_out, r_out, q_exp, busy, err, err_code};
        n_checks++;
        if (got !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_release outputs got %b want 0000000", got);
        end
    endtask

    task automatic test_round_trip();
        logic [2:0] got, want;
        int st;
        st = 10 + LAT;
        clr_req = 1'b1;
        for (int t = 1; t <= 32; t++) begin
            cyc();
            got  = {s_out, r_out, busy};
            want = {(t >= st && t < st + PW),
                    (t >= LAT && t < LAT + PW),
                    ((t >= LAT && t < LAT + PW + CD)
                     || (t >= st && t < st + PW + CD))};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL round_trip t=%0d {s,r,busy} got %b want %b",
                         t, got, want);
            end
            if (t == 10) begin
                clr_req = 1'b0;
                set_req = 1'b1;
            end
            if (t == 20) set_req = 1'b0;
        end
        got = {q_exp, q_fb, err};
        n_checks++;
        if (got !== 3'b110) begin
            n_fail++;
            $display("FAIL round_trip_end {q_exp,q_fb,err} got %b want 110",
                     got);
        end
        prev_q = 1'b1;
    endtask

    task automatic test_bounce();
        logic [1:0] got;
        for (int t = 0; t < 34; t++) begin
            set_req = (t < 20) ? (((t / 2) % 2) == 0) : 1'b0;
            cyc();
            got = {s_out, busy};
            n_checks++;
            if (got !== 2'b00) begin
                n_fail++;
                $display("FAIL bounce t=%0d {s,busy} got %b want 00", t, got);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] got, want;
        set_req = 1'b1;
        clr_req = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            cyc();
            got  = {s_out, r_out, err, err_code};
            want = {1'b0, (t >= LAT && t < LAT + PW), (t >= LAT),
                    (t >= LAT) ? 2'd2 : 2'd0};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL simultaneous t=%0d {s,r,err,code} got %b want %b",
                         t, got, want);
            end
        end
        n_checks++;
        if (q_exp !== 1'b0) begin
            n_fail++;
            $display("FAIL simultaneous_q_exp got %b want 0", q_exp);
        end
        set_req = 1'b0;
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        prev_q = 1'b0;
    endtask

    task automatic test_mismatch();
        logic [2:0] got, want;
        int ce;
        ce = LAT + PW + CD;
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        n_checks++;
        if ({err, err_code} !== 3'b000) begin
            n_fail++;
            $display("FAIL mismatch_pre_clear got %b want 000",
                     {err, err_code});
        end
        force_en  = 1'b1;
        force_val = 1'b0;
        set_req   = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            cyc();
            got  = {err, err_code};
            want = (t == ce) ? 3'b101 : 3'b000;
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL mismatch t=%0d {err,code} got %b want %b",
                         t, got, want);
            end
            if (t == 6) set_req = 1'b0;
            err_clr = (t == ce);
        end
        force_en = 1'b0;
        prev_q = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
    endtask

    task automatic test_reset_mid_pulse();
        logic [3:0] got;
        set_req = 1'b1;
        for (int t = 1; t <= LAT; t++) begin
            cyc();
            if (t == 6) set_req = 1'b0;
        end
        n_checks++;
        if ({s_out, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_pulse_pre {s,busy} got %b want 11",
                     {s_out, busy});
        end
        #1 rst = 1'b0;
        #1;
        got = {s_out, r_out, busy, q_exp};
        n_checks++;
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_pulse_reset {s,r,busy,q_exp} got %b want 0000",
                     got);
        end
        #1 rst = 1'b1;
        for (int t = 0; t < 25; t++) begin
            cyc();
            got = {s_out, r_out, busy, err};
            n_checks++;
            if (got !== 4'b0000) begin
                n_fail++;
                $display("FAIL mid_pulse_after t=%0d {s,r,busy,err} got %b want 0000",
                         t, got);
            end
        end
        prev_q = 1'b0;
    endtask

    task automatic test_overflow();
        logic [4:0] got, want;
        logic       act;
        int         e1, e2;
        e1 = LAT + PW2 + CD2;
        e2 = e1 + 1;
        s2_pulses = 0;
        set2 = 1'b1;
        for (int t = 1; t <= 80; t++) begin
            cyc();
            act  = (t >= LAT && t < LAT + PW2)
                || (t >= e2 && t < e2 + PW2);
            want = {act,
                    ((t >= LAT && t < e1) || (t >= e2 && t < e2 + PW2 + CD2)),
                    (t >= 35),
                    (t >= 35) ? 2'd3 : 2'd0};
            got  = {s_out2, busy2, err2, err_code2};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL overflow t=%0d {s,busy,err,code} got %b want %b",
                         t, got, want);
            end
            set2 = (t < 6) || (t >= 14 && t < 20) || (t >= 28 && t < 34);
        end
        n_checks++;
        if (s2_pulses != 2) begin
            n_fail++;
            $display("FAIL overflow_pulses got %0d want 2", s2_pulses);
        end
    endtask

    task automatic test_random();
        logic [5:0] got, want;
        logic       cmd, glitch, fe, qe;
        int         hold, ce;
        ce = LAT + PW + CD;
        for (int it = 0; it < 12; it++) begin
            cmd    = 1'($urandom_range(0, 1));
            glitch = 1'($urandom_range(0, 1));
            fe     = 1'($urandom_range(0, 1));
            hold   = $urandom_range(6, 10);
            if (glitch) begin
                if (cmd) set_req = 1'b1; else clr_req = 1'b1;
                repeat ($urandom_range(1, 2)) cyc();
                set_req = 1'b0;
                clr_req = 1'b0;
                repeat (3) cyc();
            end
            force_en  = fe;
            force_val = ~cmd;
            if (cmd) set_req = 1'b1; else clr_req = 1'b1;
            for (int t = 1; t <= 22; t++) begin
                cyc();
                qe   = (t >= LAT) ? cmd : prev_q;
                want = {cmd && t >= LAT && t < LAT + PW,
                        !cmd && t >= LAT && t < LAT + PW,
                        t >= LAT && t < ce,
                        qe,
                        fe && t == ce,
                        fe && t == ce};
                got  = {s_out, r_out, busy, q_exp, err, err_code == 2'd1};
                n_checks++;
                if (got !== want || (err_code !== 2'd0 && err_code !== 2'd1)) begin
                    n_fail++;
                    $display("FAIL random it=%0d t=%0d cmd=%b {s,r,busy,q,err,mm} got %b want %b code %0d",
                             it, t, cmd, got, want, err_code);
                end
                if (t == hold) begin
                    set_req = 1'b0;
                    clr_req = 1'b0;
                end
                err_clr = fe && (t == ce);
            end
            force_en = 1'b0;
            prev_q = cmd;
        end
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_bounce();
        test_simultaneous();
        test_mismatch();
        test_reset_mid_pulse();
        test_overflow();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
